// File: rtl/npc_btb_unit.sv
// -----------------------------------------------------------------------------
// npc_btb_unit -- next-PC selection for the fetch stage with an optional
// direct-mapped branch target buffer (BTB).
//
// Optional feature: define NPC_BTB_EN to build the BTB and its prediction path.
// Without it the block is a plain redirect mux with pred_taken_f tied low, and
// upd_* / btb_flush are ignored.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   stall_f             : hold the fetch PC (an EX redirect still wins)
//   branch_e, jalr_e    : EX-stage redirect requests (branch_e has priority)
//   jal_d               : ID-stage jal redirect request
//   branch_target, jalr_target, jal_target : redirect targets
//   upd_valid_e         : BTB update strobe for a resolved branch
//   upd_pc_e, upd_target_e, upd_taken_e    : resolved branch PC/target/outcome
//   btb_flush           : invalidate every BTB entry at the next edge
//   pcf                 : registered fetch PC
//   pc_in               : combinational next PC
//   pred_taken_f        : BTB predicts taken for pcf
// -----------------------------------------------------------------------------
module npc_btb_unit #(
    parameter int              XLEN      = 32,
    parameter int              BTB_DEPTH = 16,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_f,
    input  logic            branch_e,
    input  logic            jalr_e,
    input  logic            jal_d,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jalr_target,
    input  logic [XLEN-1:0] jal_target,
    input  logic            upd_valid_e,
    input  logic [XLEN-1:0] upd_pc_e,
    input  logic [XLEN-1:0] upd_target_e,
    input  logic            upd_taken_e,
    input  logic            btb_flush,
    output logic [XLEN-1:0] pcf,
    output logic [XLEN-1:0] pc_in,
    output logic            pred_taken_f
);

    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pred_target;

`ifdef NPC_BTB_EN
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [BTB_DEPTH-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q [BTB_DEPTH];
    logic [TAG_W-1:0]     tag_d [BTB_DEPTH];
    logic [XLEN-1:0]      tgt_q [BTB_DEPTH];
    logic [XLEN-1:0]      tgt_d [BTB_DEPTH];
    logic [1:0]           ctr_q [BTB_DEPTH];
    logic [1:0]           ctr_d [BTB_DEPTH];

    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             u_hit;
    logic             unused_upd_lsb;

    assign f_idx = pcf_q[IDX_W+1:2];
    assign f_tag = pcf_q[XLEN-1:IDX_W+2];
    assign u_idx = upd_pc_e[IDX_W+1:2];
    assign u_tag = upd_pc_e[XLEN-1:IDX_W+2];
    // Instructions are word aligned, so the byte offset never reaches the BTB.
    assign unused_upd_lsb = ^upd_pc_e[1:0];

    // Lookup reads only the registered arrays, so an update in flight this
    // cycle is seen by fetch one cycle later.
    assign pred_taken_f = valid_q[f_idx] && (tag_q[f_idx] == f_tag) && ctr_q[f_idx][1];
    assign pred_target  = tgt_q[f_idx];
    assign u_hit        = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned; that is what keeps latches from being inferred.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        if (btb_flush) begin
            valid_d = '0;
        end else if (upd_valid_e) begin
            if (u_hit) begin
                if (upd_taken_e) begin
                    if (ctr_q[u_idx] != 2'd3) ctr_d[u_idx] = ctr_q[u_idx] + 2'd1;
                    tgt_d[u_idx] = upd_target_e;
                end else if (ctr_q[u_idx] != 2'd0) begin
                    ctr_d[u_idx] = ctr_q[u_idx] - 2'd1;
                end
            end else if (upd_taken_e) begin
                // Allocate weakly-taken so one later not-taken demotes it.
                valid_d[u_idx] = 1'b1;
                tag_d[u_idx]   = u_tag;
                tgt_d[u_idx]   = upd_target_e;
                ctr_d[u_idx]   = 2'd2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    // NOTE: tag/target/counter storage has no reset; the valid bits alone make
    // stale contents invisible, and leaving the arrays unreset keeps them RAM-like.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
        ctr_q <= ctr_d;
    end
`else
    logic unused_btb_inputs;

    assign unused_btb_inputs = ^{upd_valid_e, upd_pc_e, upd_target_e, upd_taken_e, btb_flush};
    assign pred_taken_f      = 1'b0;
    assign pred_target       = '0;
`endif

    // Natural wrap at 2^XLEN is intended.
    assign pc_plus4 = pcf_q + XLEN'(4);

    always_comb begin
        pc_in = pc_plus4;
        if (branch_e)          pc_in = branch_target;
        else if (jalr_e)       pc_in = jalr_target;
        else if (jal_d)        pc_in = jal_target;
        else if (pred_taken_f) pc_in = pred_target;
    end

    // An EX redirect must land even while fetch is stalled, otherwise the
    // wrong-path instruction would stay in the fetch slot.
    always_comb begin
        pcf_d = pcf_q;
        if (!stall_f || branch_e || jalr_e) pcf_d = pc_in;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pcf_q <= RESET_PC;
        else        pcf_q <= pcf_d;
    end

    assign pcf = pcf_q;

endmodule
